// File: rtl/transfer_register_v2.sv
// Transfer register with post-step addressing and a block-length counter.
// Define TXREG_WRAP_DETECT_EN to enable the one-cycle wrap flag.
module transfer_register_v2 #(
  parameter int DATA_W = 8,
  parameter int XFER_W = 16,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              reset,
  inout  wire  [DATA_W-1:0] MainBus,
  inout  wire  [XFER_W-1:0] Addr,
  inout  wire  [XFER_W-1:0] Bus,
  input  logic              a_tl,
  input  logic              a_th,
  input  logic              l_tl,
  input  logic              l_th,
  input  logic              l_tx,
  input  logic              a_tx_addr,
  input  logic              a_tx_xfer,
  input  logic              l_cnt,
  input  logic              step_en,
  input  logic              step_dir,
  output logic              cnt_zero,
  output logic              wrap
);

  localparam logic [XFER_W-1:0] TX_ONE  = XFER_W'(1);
  localparam logic [CNT_W-1:0]  CNT_ONE = CNT_W'(1);

  logic [XFER_W-1:0] tx;
  logic [XFER_W-1:0] tx_nxt;
  logic [CNT_W-1:0]  cnt;
  logic [CNT_W-1:0]  cnt_nxt;
  logic              tx_load;
  logic              step_ok;
  logic              tx_step;

  // A counter load suppresses the TX half of an otherwise accepted step.
  always_comb begin
    tx_load = l_tx | l_tl | l_th;
    step_ok = step_en & (cnt != '0) & ~tx_load;
    tx_step = step_ok & ~l_cnt;
  end

  always_comb begin
    tx_nxt = tx;
    if (l_tx) begin
      tx_nxt = Bus;
    end else if (l_tl || l_th) begin
      if (l_tl)
        tx_nxt[DATA_W-1:0] = MainBus;
      if (l_th)
        tx_nxt[XFER_W-1:DATA_W] = MainBus;
    end else if (tx_step) begin
      tx_nxt = step_dir ? tx - TX_ONE
                        : tx + TX_ONE;
    end
  end

  always_comb begin
    cnt_nxt = cnt;
    if (l_cnt)
      cnt_nxt = CNT_W'(MainBus);
    else if (tx_step)
      cnt_nxt = cnt - CNT_ONE;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      tx  <= '0;
      cnt <= '0;
    end else begin
      tx  <= tx_nxt;
      cnt <= cnt_nxt;
    end
  end

  assign cnt_zero = (cnt == '0);

`ifdef TXREG_WRAP_DETECT_EN
  logic wrap_q;
  logic wrap_nxt;

  always_comb begin
    wrap_nxt = 1'b0;
    if (tx_step)
      wrap_nxt = step_dir ? (tx == '0)
                          : (tx == '1);
  end

  always_ff @(posedge clk) begin
    if (reset)
      wrap_q <= 1'b0;
    else
      wrap_q <= wrap_nxt;
  end

  assign wrap = wrap_q;
`else
  assign wrap = 1'b0;
`endif

  // Drivers always present current TX; a_tl wins over a_th.
  assign MainBus = a_tl ? tx[DATA_W-1:0]
                 : a_th ? tx[XFER_W-1:DATA_W]
                 : {DATA_W{1'bz}};

  assign Addr = a_tx_addr ? tx : {XFER_W{1'bz}};
  assign Bus  = a_tx_xfer ? tx : {XFER_W{1'bz}};

endmodule

// File: doc/transfer_register_v2.md
# transfer_register_v2

Parametrised transfer register with post-step addressing and a block-length counter. Holds one XFER_W-bit value that loads byte-wise from the main bus or whole from the transfer bus. It can drive the main, address or transfer bus, and can auto-increment or decrement by one per step while a down-counter tracks the remaining transfer length. It replaces the fixed 16-bit transfer register in the pipelined CPU's memory-transfer path and enables memcpy-style block moves without ALU involvement.

## Interface
Parameters:
- DATA_W, 8, main bus width
- XFER_W, 16, transfer/address width; must equal 2*DATA_W
- CNT_W, 8, block-length counter width

Ports:
- clk  in  1  system clock; all state changes on rising edge
- reset  in  1  synchronous, active-high reset
- MainBus  inout  DATA_W  system bus; tri-stated unless a_tl/a_th
- Addr  inout  XFER_W  address bus; tri-stated unless a_tx_addr
- Bus  inout  XFER_W  transfer bus; tri-stated unless a_tx_xfer
- a_tl  in  1  drive TX[DATA_W-1:0] onto MainBus
- a_th  in  1  drive TX[XFER_W-1:DATA_W] onto MainBus
- l_tl  in  1  load TX low half from MainBus
- l_th  in  1  load TX high half from MainBus
- l_tx  in  1  load full TX from Bus
- a_tx_addr  in  1  drive TX onto Addr
- a_tx_xfer  in  1  drive TX onto Bus
- l_cnt  in  1  load counter from MainBus (zero-extended or truncated to CNT_W)
- step_en  in  1  request one post-step
- step_dir  in  1  0 = increment, 1 = decrement
- cnt_zero  out  1  counter == 0
- wrap  out  1  step wrapped (see Configuration)

All control inputs are active-high.

## Operation
- State: TX (XFER_W), CNT (CNT_W), wrap_q (1).
- TX update priority per edge: reset > l_tx > (l_tl / l_th) > step.
- l_tl and l_th may both be asserted in one cycle. Each loads its own half from the same MainBus byte.
- Step is accepted only when step_en=1, CNT≠0 and no TX load is active in that cycle.
  - Accepted step: TX ← TX ± 1 modulo 2^XFER_W; CNT ← CNT−1.
- Step with CNT==0 is ignored: TX, CNT and wrap are unchanged.
- l_cnt is independent of TX loads. When l_cnt and an accepted step coincide, l_cnt wins: CNT ← MainBus and the TX step is suppressed.
- MainBus drive: a_tl has priority over a_th. If both are high, only the low half is driven.
- Addr and Bus drivers are independent and may be active simultaneously.
- Driven values are always current TX, never the value being loaded.
- A load and an assert of the same bus in one cycle is legal: the block drives old TX and captures it unchanged. Only l_tx+a_tx_xfer and l_tl+a_tl/l_th+a_th self-loop in this way.
- cnt_zero is combinational from CNT.

## Timing
- Reset (sync, active-high): TX=0, CNT=0, wrap=0, cnt_zero=1. All buses are Z during and after reset until asserted.
- Reset mid-block-move aborts immediately. Steps requested in the reset cycle are discarded.
- Load latency: 1 cycle. The new value is visible on the drivers after the capturing edge.
- Step latency: 1 cycle. The incremented TX appears on Addr the cycle after step_en.
- Back-to-back steps every cycle are supported. N steps after loading CNT=N leave cnt_zero=1 on the Nth edge.
- Bus enables are combinational. Drive begins and ends in the same cycle as the assert input.

## Configuration
- Macro TXREG_WRAP_DETECT_EN.
- Defined:
  - wrap goes high for exactly one cycle following an accepted step that crossed a boundary: inc all-ones→0 or dec 0→all-ones.
  - wrap clears on the next edge, and on reset.
- Undefined: wrap is tied 0 and wrap_q is not synthesised. All other behaviour is identical.

## Test plan
- Byte load: MainBus=0x34 with l_tl, then 0x12 with l_th, then a_tx_addr → Addr=0x1234. Then a_th → MainBus=0x12.
- Block increment: l_tx with Bus=0x00FE, l_cnt with MainBus=3, step_en×4 with step_dir=0 → Addr goes 0x00FF, 0x0100, 0x0101, then holds. cnt_zero rises after the 3rd step.
- Wrap: TX=0x0000, CNT=1, step_dir=1 → TX=0xFFFF. wrap=1 for one cycle with TXREG_WRAP_DETECT_EN, 0 without.
- Priority: l_tx (Bus=0xBEEF) with step_en, CNT=5 → TX=0xBEEF, CNT stays 5. l_cnt with step_en → CNT loaded, TX unchanged.
- Contention/self-loop: a_tl+a_th with TX=0xA55A → MainBus=0x5A. l_tx+a_tx_xfer → TX remains 0xA55A.
- Reset mid-move: during stepping with CNT=4, assert reset for 1 cycle → TX=0, CNT=0, cnt_zero=1, all buses Z, and no step occurs.
